// File: rtl/rw_2d_ram_pkg.sv
// Shared types for the 2-D RAM reader/responder pair.
// Contents: FSM state enum and the address-width helper.
package rw_2d_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address width for a power-of-two RAM depth.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rw_2d_ram_reader_if.sv
// Bundle of the reader's command, RAM read-request/response and output
// stream channels.
// master: the reader (drives cmd_ready, request, rready, stream, done).
// slave : the environment (sequencer + responder + downstream sink).
interface rw_2d_ram_reader_if
  import rw_2d_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned AW = calc_aw(DEPTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_base;
  logic [AW:0]      cmd_len;
  logic [AW-1:0]    cmd_stride;
  logic             m_arvalid;
  logic [AW-1:0]    m_raddr;
  logic             m_arready;
  logic [WIDTH-1:0] m_rdata;
  logic             m_rvalid;
  logic             m_rready;
  logic [WIDTH-1:0] out_tdata;
  logic             out_tvalid;
  logic             out_tready;
  logic             out_tlast;
  logic             done;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, cmd_stride,
    input  m_arready, m_rdata, m_rvalid, out_tready,
    output cmd_ready, m_arvalid, m_raddr, m_rready,
    output out_tdata, out_tvalid, out_tlast, done
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, cmd_stride,
    output m_arready, m_rdata, m_rvalid, out_tready,
    input  cmd_ready, m_arvalid, m_raddr, m_rready,
    input  out_tdata, out_tvalid, out_tlast, done
  );

endinterface

// File: rtl/rw_2d_ram_credit_ctr.sv
// Outstanding-read credit counter.
// Ports: clk, rst_n, i_clr (sync clear), i_inc (request accepted),
//        i_dec (response consumed), o_can_issue (count below MAX).
module rw_2d_ram_credit_ctr #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_can_issue
);
  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  // Simultaneous inc and dec leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_can_issue = (r_cnt < CW'(MAX));

endmodule

// File: rtl/rw_2d_ram_reader.sv
// Read-side initiator for the 2-D RAM responder: takes one command
// (base, len, stride), issues strided read requests under a credit cap and
// passes returned words straight to the output stream with tlast.
// Ports: clk, rst_n, bus (rw_2d_ram_reader_if.master: command, RAM read
//        request/response, output stream, done pulse).
module rw_2d_ram_reader
  import rw_2d_ram_pkg::*;
#(
  parameter int unsigned DEPTH           = 32,
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rw_2d_ram_reader_if.master    bus
);
  localparam int unsigned AW = calc_aw(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_stride;
  logic [LW-1:0] r_issue_cnt;
  logic [LW-1:0] r_beat_cnt;
  logic          r_cmd_ready;
  logic          r_done;

  logic w_in_run;
  logic w_accept;
  logic w_issue;
  logic w_beat;
  logic w_last;
  logic w_can_issue;

  assign w_in_run = (r_state == RUN);
  assign w_accept = bus.cmd_valid && r_cmd_ready;
  assign w_issue  = bus.m_arvalid && bus.m_arready;
  assign w_beat   = bus.m_rvalid && bus.m_rready;
  assign w_last   = (r_beat_cnt == LW'(1));

  // Request side: held until accepted since inputs only change on handshake.
  assign bus.m_arvalid = w_in_run && (r_issue_cnt != '0) && w_can_issue;
  assign bus.m_raddr   = r_addr;

  // Response side: zero-latency pass-through, gated off outside RUN.
  assign bus.m_rready   = w_in_run && bus.out_tready;
  assign bus.out_tvalid = w_in_run && bus.m_rvalid;
  assign bus.out_tdata  = w_in_run ? bus.m_rdata : '0;
  assign bus.out_tlast  = w_in_run && w_last;

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.done      = r_done;

  rw_2d_ram_credit_ctr #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_accept),
    .i_inc       (w_issue),
    .i_dec       (w_beat),
    .o_can_issue (w_can_issue)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = (bus.cmd_len == '0) ? DONE : RUN;
      RUN:     if (w_beat && w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // cmd_ready/done registered from next state so both track state exactly,
  // while cmd_ready stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == IDLE);
      r_done      <= (w_next_state == DONE);
    end
  end

  // Address generator and beat/issue counters; AW-bit add wraps mod DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_stride    <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
    end else if (w_accept) begin
      r_addr      <= bus.cmd_base;
      r_stride    <= bus.cmd_stride;
      r_issue_cnt <= bus.cmd_len;
      r_beat_cnt  <= bus.cmd_len;
    end else if (w_in_run) begin
      if (w_issue) begin
        r_addr      <= r_addr + r_stride;
        r_issue_cnt <= r_issue_cnt - LW'(1);
      end
      if (w_beat) begin
        r_beat_cnt <= r_beat_cnt - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rw_2d_ram_reader.sv
// Self-checking bench for rw_2d_ram_reader with a behavioural RAM responder.
module tb_rw_2d_ram_reader;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rw_2d_ram_reader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  rw_2d_ram_reader #(
    .DEPTH           (DEPTH),
    .WIDTH           (WIDTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rq [$];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 0);
    chk({tag, "_arvalid"},   64'(bus.m_arvalid), 0);
    chk({tag, "_raddr"},     64'(bus.m_raddr), 0);
    chk({tag, "_rready"},    64'(bus.m_rready), 0);
    chk({tag, "_tvalid"},    64'(bus.out_tvalid), 0);
    chk({tag, "_tdata"},     64'(bus.out_tdata), 0);
    chk({tag, "_tlast"},     64'(bus.out_tlast), 0);
    chk({tag, "_done"},      64'(bus.done), 0);
  endtask

  // One command: rnd randomises ready inputs, stall holds out_tready low for
  // that many cycles, abort_after>0 pulls reset after that many beats.
  task automatic run_cmd(input int base, input int len, input int stride,
                         input bit rnd, input int stall, input int abort_after);
    int addrs[$];
    logic [WIDTH-1:0] exp_data[$];
    int issued, returned;
    bit exp_done, fin, aborted, prev_stall, rdy;
    logic [AW-1:0] prev_addr;
    for (int k = 0; k < len; k++) begin
      addrs.push_back((base + k * stride) % DEPTH);
      exp_data.push_back(mem[(base + k * stride) % DEPTH]);
    end
    rdy = 0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      bus.cmd_valid  = 1'b1;
      bus.cmd_base   = AW'(base);
      bus.cmd_len    = (AW+1)'(len);
      bus.cmd_stride = AW'(stride);
      bus.m_rvalid   = 1'b0;
      bus.m_arready  = 1'b1;
      bus.out_tready = 1'b1;
      #1;
      rdy = bus.cmd_ready;
    end
    chk("cmd_ready", 64'(rdy), 1);
    chk("idle_arvalid", 64'(bus.m_arvalid), 0);
    @(posedge clk);
    issued = 0; returned = 0; fin = 0; aborted = 0; prev_stall = 0;
    exp_done = (len == 0);
    prev_addr = '0;
    for (int cyc = 0; cyc < 3000 && !fin && !aborted; cyc++) begin
      @(negedge clk);
      bus.cmd_valid  = 1'b0;
      bus.cmd_base   = AW'($urandom);
      bus.m_arready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_tready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.m_rvalid   = (rq.size() != 0);
      bus.m_rdata    = (rq.size() != 0) ? rq[0] : WIDTH'($urandom);
      #1;
      chk("done", 64'(bus.done), 64'(exp_done));
      fin = exp_done;
      exp_done = 0;
      chk("arvalid", 64'(bus.m_arvalid),
          64'(issued < len && (issued - returned) < int'(MAXO)));
      if (prev_stall) chk("raddr_hold", 64'(bus.m_raddr), 64'(prev_addr));
      chk("rready", 64'(bus.m_rready), 64'(!fin && bus.out_tready));
      chk("tvalid", 64'(bus.out_tvalid), 64'(!fin && bus.m_rvalid));
      if (bus.m_arvalid && bus.m_arready) begin
        if (issued < len) chk("raddr", 64'(bus.m_raddr), 64'(addrs[issued]));
        rq.push_back(mem[bus.m_raddr]);
        issued++;
      end
      prev_stall = bus.m_arvalid && !bus.m_arready;
      prev_addr  = bus.m_raddr;
      if (bus.out_tvalid && bus.out_tready) begin
        if (returned < len) chk("tdata", 64'(bus.out_tdata), 64'(exp_data[returned]));
        chk("tlast", 64'(bus.out_tlast), 64'(returned == len - 1));
        void'(rq.pop_front());
        returned++;
        if (returned == len) exp_done = 1;
        if (abort_after > 0 && returned == abort_after) aborted = 1;
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst_n        = 1'b0;
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = WIDTH'($urandom);
      #1;
      check_all_zero("abort");
      rq.delete();
      @(negedge clk);
      rst_n        = 1'b1;
      bus.m_rvalid = 1'b0;
      #1;
      chk("abort_release_cmd_ready", 64'(bus.cmd_ready), 0);
      @(negedge clk);
      #1;
      chk("abort_cmd_ready", 64'(bus.cmd_ready), 1);
    end else begin
      chk("timeout", 64'(fin), 1);
      chk("beats", 64'(returned), 64'(len));
      chk("reqs", 64'(issued), 64'(len));
      @(negedge clk);
      bus.m_rvalid = 1'b0;
      #1;
      chk("done_one_cycle", 64'(bus.done), 0);
      chk("cmd_ready_after_done", 64'(bus.cmd_ready), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = WIDTH'($urandom);
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_len    = '0;
    bus.cmd_stride = '0;
    bus.m_arready  = 1'b1;
    bus.m_rvalid   = 1'b1;
    bus.m_rdata    = WIDTH'($urandom);
    bus.out_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n        = 1'b1;
    bus.m_rvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_cmd_ready", 64'(bus.cmd_ready), 1);

    run_cmd(4, 3, 1, 0, 0, 0);
    run_cmd(30, 4, 1, 0, 0, 0);
    run_cmd(9, 0, 3, 0, 0, 0);
    run_cmd(0, 8, 3, 0, 10, 0);
    run_cmd(7, 32, 0, 0, 0, 0);
    run_cmd(31, 32, 1, 1, 0, 0);
    for (int t = 0; t < 12; t++) begin
      run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)),
              int'($urandom_range(0, DEPTH - 1)), 1, int'($urandom_range(0, 5)), 0);
    end
    run_cmd(5, 8, 1, 0, 0, 3);
    run_cmd(7, 5, 2, 0, 0, 0);
    run_cmd(20, 6, 13, 1, 3, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rw_2d_ram_reader.md
# rw_2d_ram_reader

Read-side initiator for the 2-D RAM responder. Accepts a single command (base address, beat count, stride), issues the address requests on the RAM read-request channel, and streams the returned words out with a last marker. An outstanding-request credit counter caps in-flight reads, so the responder's read-data FIFO can never overflow. Sits between a control/DMA sequencer and the RAM's read interface.

## Interface
- DEPTH, 32, RAM word count; must be a power of two ≥ 2; AW = $clog2(DEPTH)
- WIDTH, 32, data word width
- MAX_OUTSTANDING, 8, maximum issued-but-unreturned reads; 1..DEPTH
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offer
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  AW  first address
- cmd_len  in  AW+1  beat count, 0..DEPTH
- cmd_stride  in  AW  address increment per beat, modulo DEPTH
- m_arvalid  out  1  read request valid
- m_raddr  out  AW  read address
- m_arready  in  1  responder accepts request
- m_rdata  in  WIDTH  returned data
- m_rvalid  in  1  returned data valid
- m_rready  out  1  this block accepts returned data
- out_tdata  out  WIDTH  output stream data
- out_tvalid  out  1  output valid
- out_tready  in  1  downstream ready
- out_tlast  out  1  final beat of command
- done  out  1  one-cycle pulse after final beat (or after a zero-length command)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cmd_ready=1, m_arvalid=0, m_rready=0, out_tvalid=0. On cmd_valid&cmd_ready latch base/len/stride; len=0 → DONE, else → RUN with addr=base, issue_cnt=len, beat_cnt=len, credits=0.
- RUN request side: m_arvalid=1 while issue_cnt>0 and credits<MAX_OUTSTANDING. On m_arvalid&m_arready: addr←(addr+stride) mod DEPTH, issue_cnt−1, credits+1. m_arvalid and m_raddr stay stable until accepted (no withdrawal).
- RUN response side: out_tdata=m_rdata, out_tvalid=m_rvalid, m_rready=out_tready (zero-latency pass-through). On m_rvalid&m_rready: beat_cnt−1, credits−1. out_tlast=1 when beat_cnt==1.
- Same-cycle issue and return: credits unchanged.
- Final beat handshake → DONE. DONE: done=1 for exactly one cycle → IDLE.
- Stride 0: same address read len times. Wrap: addr DEPTH−1 + stride 1 → 0.
- Responses arriving in IDLE/DONE are not accepted (m_rready=0); none can exist in normal operation since credits reach 0 before DONE.

## Timing
- Reset values: cmd_ready=0 during reset then 1 (IDLE), all other outputs 0, counters 0, m_raddr 0.
- Cmd accepted at edge N → first m_arvalid in cycle N+1 with m_raddr=base.
- Max one request and one beat per cycle; full throughput when m_arready and out_tready held high.
- Data latency input→output: 0 cycles (combinational).
- done asserted in the cycle after the tlast handshake; cmd_ready high the cycle after done.
- Reset mid-command: immediate return to IDLE, counters cleared, arvalid dropped; responder shares rst_n and flushes its own FIFO.

## Structure
- Package rw_2d_ram_pkg: state enum (IDLE/RUN/DONE), AW helper function. Shared with the responder.
- One sub-module: rw_2d_ram_credit_ctr (up/down counter, MAX parameter, inc/dec inputs, can_issue output).
- Address generator and FSM stay in the top module.

## Test plan
- Base 4, len 3, stride 1, responder ready always, out_tready=1 → raddr 4,5,6 on consecutive cycles; three beats, tlast on third; done one cycle later.
- Base 30, len 4, stride 1, DEPTH 32 → raddr 30,31,0,1 (wrap).
- len 0 → no m_arvalid, no beats, done one cycle after command accept.
- MAX_OUTSTANDING 2, out_tready=0 for 10 cycles, len 8 → exactly 2 requests issued, then m_arvalid=0 until beats drain; all 8 beats delivered in order.
- m_arready toggling pseudo-randomly → m_raddr/m_arvalid stable while stalled; returned sequence matches written RAM contents at base+k·stride.
- Assert rst_n low mid-RUN (after 3 of 8 beats) → all outputs 0 next cycle, cmd_ready high after release; new command completes normally.
